// File: rtl/scarv_cop_common.sv
//============================================================================
// scarv_cop_common - shared FSM encodings and port indices. Rev 1.0
//============================================================================
`default_nettype none

package scarv_cop_common;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic HOST = 1'b0;
  localparam logic COP  = 1'b1;

  // A zero timeout still needs a 1-bit counter to keep the vector legal.
  function automatic int unsigned tmo_cnt_width(input int unsigned tmo);
    return (tmo == 0) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/scarv_rr_pick2.sv
//============================================================================
// scarv_rr_pick2 - two-requester round-robin pick. Rev 1.0
//============================================================================
`default_nettype none

module scarv_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  always_comb begin
    gnt = 1'b0;
    if (req == 2'b11) begin
      gnt = ~last;
    end else begin
      gnt = req[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/scarv_mem_arbiter.sv
//============================================================================
// scarv_mem_arbiter - host/coprocessor arbiter onto one memory bus. Rev 1.0
//============================================================================
`default_nettype none

module scarv_mem_arbiter
  import scarv_cop_common::*;
#(
  parameter int unsigned TMO_CYCLES = 64
) (
  input  logic        g_clk,
  input  logic        g_reset,

  input  logic        host_mem_cen,
  input  logic        host_mem_wen,
  input  logic [31:0] host_mem_addr,
  input  logic [31:0] host_mem_wdata,
  input  logic [3:0]  host_mem_ben,
  output logic [31:0] host_mem_rdata,
  output logic        host_mem_stall,
  output logic        host_mem_error,

  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  input  logic [3:0]  cop_mem_ben,
  output logic [31:0] cop_mem_rdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error,

  output logic        mem_cen,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_ben,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall,
  input  logic        mem_error,

  output logic        arb_timeout
);

  localparam int unsigned      CNT_W    = tmo_cnt_width(TMO_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYCLES == 0) ? 0 : TMO_CYCLES - 1);

  arb_state_t       r_state;
  logic             r_gnt;
  logic             r_lgnt;
  logic [CNT_W-1:0] r_cnt;

  logic        w_pick;
  logic        w_any;
  logic        w_busy;
  logic        w_sel;
  logic        w_cmpl;
  logic        w_tmo;
  logic        w_done;
  logic        w_sel_cen;
  logic        w_sel_wen;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_ben;

  scarv_rr_pick2 u_pick (
    .req  ({cop_mem_cen, host_mem_cen}),
    .last (r_lgnt),
    .gnt  (w_pick)
  );

  assign w_any  = host_mem_cen | cop_mem_cen;
  assign w_busy = (r_state == ARB_BUSY);
  assign w_sel  = w_busy ? r_gnt : w_pick;

  assign w_sel_cen   = (w_sel == COP) ? cop_mem_cen   : host_mem_cen;
  assign w_sel_wen   = (w_sel == COP) ? cop_mem_wen   : host_mem_wen;
  assign w_sel_addr  = (w_sel == COP) ? cop_mem_addr  : host_mem_addr;
  assign w_sel_wdata = (w_sel == COP) ? cop_mem_wdata : host_mem_wdata;
  assign w_sel_ben   = (w_sel == COP) ? cop_mem_ben   : host_mem_ben;

  // A real completion in the same cycle wins over the timeout.
  assign w_cmpl = w_busy & ~mem_stall;
  assign w_tmo  = (TMO_CYCLES != 0) & w_busy & mem_stall & (r_cnt == TMO_LAST);
  assign w_done = w_cmpl | w_tmo;

  always_comb begin
    mem_cen        = 1'b0;
    mem_wen        = 1'b0;
    mem_addr       = 32'h0;
    mem_wdata      = 32'h0;
    mem_ben        = 4'h0;
    host_mem_stall = 1'b1;
    host_mem_rdata = 32'h0;
    host_mem_error = 1'b0;
    cop_mem_stall  = 1'b1;
    cop_mem_rdata  = 32'h0;
    cop_mem_error  = 1'b0;
    arb_timeout    = 1'b0;
    if (!g_reset && (w_busy || w_any)) begin
      mem_cen   = w_sel_cen & ~w_done;
      mem_wen   = w_sel_wen;
      mem_addr  = w_sel_addr;
      mem_wdata = w_sel_wdata;
      mem_ben   = w_sel_ben;
      if (w_busy) begin
        arb_timeout = w_tmo;
        if (r_gnt == COP) begin
          cop_mem_stall  = ~w_done;
          cop_mem_rdata  = w_cmpl ? mem_rdata : 32'h0;
          cop_mem_error  = w_cmpl ? mem_error : w_tmo;
        end else begin
          host_mem_stall = ~w_done;
          host_mem_rdata = w_cmpl ? mem_rdata : 32'h0;
          host_mem_error = w_cmpl ? mem_error : w_tmo;
        end
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state <= ARB_IDLE;
      r_gnt   <= HOST;
      r_lgnt  <= COP;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state <= ARB_BUSY;
            r_gnt   <= w_pick;
            r_lgnt  <= w_pick;
            r_cnt   <= '0;
          end
        end
        ARB_BUSY: begin
          if (w_done) begin
            r_state <= ARB_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
